// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory port between instruction fetch and data access.
//   Data requests win over fetches; one transaction is outstanding at a time.
//   A branch flush cancels the ack of an in-flight fetch but never retracts a
//   command already presented to memory.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   if_req/if_addr/flush         fetch request, PC, branch flush
//   if_ack/if_rdata/if_stall     fetch completion, instruction, IF stall
//   d_req/d_we/d_addr/d_wdata    data request, store select, address, store data
//   d_ack/d_rdata/d_stall        data completion, load data, MEM stall
//   mem_valid/mem_cmd/mem_addr/mem_wdata  registered command toward memory
//   mem_ready                    memory accepts the command this cycle
//   mem_resp_valid/mem_rdata     read data return
//   mem_err                      sticky response-timeout flag
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        flush,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  output logic        if_stall,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_stall,
  output logic        mem_valid,
  output logic [1:0]  mem_cmd,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata,
  output logic        mem_err
);

  localparam logic [1:0] IDLE        = 2'd0;
  localparam logic [1:0] WAIT_ACCEPT = 2'd1;
  localparam logic [1:0] WAIT_RESP   = 2'd2;

  localparam logic [1:0] CMD_NONE  = 2'd0;
  localparam logic [1:0] CMD_LOAD  = 2'd1;
  localparam logic [1:0] CMD_STORE = 2'd2;
  localparam logic [1:0] CMD_FETCH = 2'd3;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  // Last counter value before giving up on a response.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0] state;
  logic       owner;
  logic       drop;
  logic [7:0] cnt;

  logic accepted;
  logic resp_done;

  assign accepted  = (state == WAIT_ACCEPT) && mem_ready;
  assign resp_done = (state == WAIT_RESP) && mem_resp_valid;

  // Acks are combinational so a store completes in its accept cycle and a
  // read completes in its response cycle. A flush in the response cycle
  // still suppresses the fetch ack.
  assign d_ack  = (accepted && (mem_cmd == CMD_STORE)) || (resp_done && (owner == OWN_D));
  assign if_ack = resp_done && (owner == OWN_IF) && !drop && !flush;

  assign if_stall = if_req & ~if_ack;
  assign d_stall  = d_req & ~d_ack;

  assign if_rdata = mem_rdata;
  assign d_rdata  = mem_rdata;

  // Transaction sequencer: command register, owner/drop tracking, timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= OWN_IF;
      drop      <= 1'b0;
      cnt       <= 8'd0;
      mem_valid <= 1'b0;
      mem_cmd   <= CMD_NONE;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (d_req) begin
            mem_valid <= 1'b1;
            mem_cmd   <= d_we ? CMD_STORE : CMD_LOAD;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            owner     <= OWN_D;
            drop      <= 1'b0;
            state     <= WAIT_ACCEPT;
          end else if (if_req && !flush) begin
            mem_valid <= 1'b1;
            mem_cmd   <= CMD_FETCH;
            mem_addr  <= {if_addr[31:2], 2'b00};
            owner     <= OWN_IF;
            drop      <= 1'b0;
            state     <= WAIT_ACCEPT;
          end else begin
            mem_valid <= 1'b0;
            mem_cmd   <= CMD_NONE;
          end
        end
        WAIT_ACCEPT: begin
          // The command stays on the bus even when flushed; only the ack is lost.
          if ((owner == OWN_IF) && flush) begin
            drop <= 1'b1;
          end
          if (mem_ready) begin
            mem_valid <= 1'b0;
            mem_cmd   <= CMD_NONE;
            cnt       <= 8'd0;
            state     <= (mem_cmd == CMD_STORE) ? IDLE : WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          if ((owner == OWN_IF) && flush) begin
            drop <= 1'b1;
          end
          if (mem_resp_valid) begin
            state <= IDLE;
          end else if (cnt == CNT_LAST) begin
            // Abandon the transaction without an ack; requester stays stalled.
            mem_err <= 1'b1;
            state   <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          state     <= IDLE;
          mem_valid <= 1'b0;
          mem_cmd   <= CMD_NONE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the processor's single memory port between instruction fetch (IF stage) and data access (MEM stage). Data accesses have fixed priority over fetches. Branch flushes cancel in-flight fetches without breaking the memory handshake. The block sequences one outstanding transaction at a time and produces the stall signals that freeze the IF and MEM stages while they wait.

## Interface
Parameters:
- TIMEOUT, 255: maximum cycles in WAIT_RESP before abort; 1..255.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- if_req  in  1  fetch request; level, held until if_ack or flush.
- if_addr  in  32  fetch PC.
- flush  in  1  taken branch from EX; cancels the current fetch.
- if_ack  out  1  fetch data valid, one cycle.
- if_rdata  out  32  fetched instruction; valid with if_ack.
- if_stall  out  1  if_req & ~if_ack.
- d_req  in  1  data request; level, held stable until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  data address.
- d_wdata  in  32  store data.
- d_ack  out  1  data access complete, one cycle.
- d_rdata  out  32  load data; valid with d_ack on loads.
- d_stall  out  1  d_req & ~d_ack.
- mem_valid  out  1  command valid toward memory.
- mem_cmd  out  2  0 = NONE, 1 = LOAD, 2 = STORE, 3 = FETCH.
- mem_addr  out  32  command address.
- mem_wdata  out  32  store data.
- mem_ready  in  1  memory accepts the command this cycle.
- mem_resp_valid  in  1  read data return, one cycle.
- mem_rdata  in  32  read data.
- mem_err  out  1  sticky timeout error.

## Operation
- States: IDLE, WAIT_ACCEPT, WAIT_RESP. Registers: owner (IF/D), drop flag, wait counter (8 bit), and the registered command (valid, cmd, addr, wdata).
- IDLE:
  - If d_req is high, latch the data command. cmd is STORE if d_we, else LOAD. owner = D. Go to WAIT_ACCEPT.
  - Else, if if_req & ~flush, latch cmd = FETCH with addr = {if_addr[31:2], 2'b00}. owner = IF, drop = 0. Go to WAIT_ACCEPT.
  - Else stay in IDLE with mem_valid = 0 and mem_cmd = NONE.
- WAIT_ACCEPT:
  - mem_valid = 1. mem_cmd, mem_addr and mem_wdata are held constant until mem_ready. They are never retracted, even on flush.
  - On mem_ready with STORE: d_ack = 1 in the same cycle, then go to IDLE.
  - On mem_ready with LOAD or FETCH: go to WAIT_RESP and clear the counter.
- WAIT_RESP:
  - mem_valid = 0.
  - On mem_resp_valid, go to IDLE. If owner = D: d_ack = 1 and d_rdata = mem_rdata. If owner = IF and ~drop and ~flush: if_ack = 1 and if_rdata = mem_rdata. Otherwise the response is discarded silently.
  - With no response, the counter increments each cycle. When the counter reaches TIMEOUT-1 without a response: set mem_err, go to IDLE, and raise no ack. The requester keeps stalling; recovery is by rst.
- Flush:
  - When owner = IF in WAIT_ACCEPT or WAIT_RESP, flush sets drop.
  - In IDLE, flush blocks fetch issue that cycle.
  - Flush has no effect on data transactions.
- mem_err is sticky. Only rst clears it.
- if_rdata and d_rdata pass mem_rdata through combinationally. Their value is meaningful only while the matching ack is high.

## Timing
- Reset values: state IDLE, mem_valid 0, mem_cmd NONE, mem_addr 0, mem_wdata 0, if_ack 0, d_ack 0, mem_err 0, drop 0, counter 0. if_stall and d_stall follow if_req and d_req.
- Command outputs are registered. A request sampled in IDLE at cycle N drives mem_valid at N+1.
- Acks are combinational from mem_ready (stores) or mem_resp_valid (reads). There are no registered acks.
- Minimum latencies:
  - Fetch or load: request at N, accept at N+1, response and ack at N+2.
  - Store: ack at N+1.
- After any ack, the state returns to IDLE. The next request is sampled in the following cycle, so reads have a 3-cycle minimum throughput.
- A requester that deasserts req while the block owns a transaction does not abort it. The transaction runs to completion. Only a flushed fetch loses its ack.
- A response arriving in WAIT_ACCEPT or IDLE is ignored.
- rst mid-transaction returns to IDLE immediately. The memory side is reset alongside this block.

## Test plan
- Single fetch: if_req = 1, if_addr = 0x12, mem_ready high, response next cycle with 0xDEADBEEF. Expected: mem_valid at cycle 1 with cmd FETCH and addr 0x10; if_ack at cycle 2 with if_rdata = 0xDEADBEEF; if_stall high at cycles 0-1.
- Contention: if_req and d_req (load, 0x100) both set at cycle 0. Expected: LOAD 0x100 issues first, d_ack at cycle 2; FETCH issues at cycle 4; if_stall stays high until if_ack at cycle 5.
- Store: d_we = 1, d_addr = 0x200, d_wdata = 0x55, mem_ready low for 3 cycles. Expected: mem_valid/STORE/0x200/0x55 held stable for 4 cycles; d_ack in the mem_ready cycle; no wait for a response.
- Flush in WAIT_RESP: fetch 0x40 accepted, flush pulses, then response 0x1234 arrives. Expected: if_ack stays 0. The next fetch issues at the new if_addr 0x80 and acks normally.
- Flush in the same cycle as the response: expected if_ack = 0 and the state returns to IDLE.
- Timeout with TIMEOUT = 4: load accepted, no response. Expected: mem_err = 1 after 4 WAIT_RESP cycles; state goes to IDLE; no d_ack; mem_err stays high until rst, which clears it.
